inv_sbox_iter: RTL and testbench

INV_SBOX_ITER -- requirements
Module: inv_sbox_iter

---
 rtl/inv_sbox_iter.sv | 75 +++++++
 tb/tb_inv_sbox_iter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_iter.sv
// inv_sbox_iter: iterative AES inverse S-box (inverse affine, then y^254 by square-and-multiply)
module inv_sbox_iter (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] byte_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] byte_out,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] y_q, y_d, t_q, t_d, out_q, out_d, aff, sq, sqy;
  logic [2:0] cnt_q, cnt_d;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  assign aff = {byte_in[6:0], byte_in[7]} ^ {byte_in[4:0], byte_in[7:5]} ^
               {byte_in[1:0], byte_in[7:2]} ^ 8'h05;
  assign sq  = gmul(t_q, t_q);
  assign sqy = gmul(sq, y_q);
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = CALC;
        y_d     = aff;
        t_d     = aff;
        cnt_d   = 3'd0;
      end
      CALC: if (cnt_q == 3'd6) begin
        t_d     = sq;
        out_d   = sq;
        state_d = DONE;
      end else begin
        t_d   = sqy;
        cnt_d = cnt_q + 3'd1;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= 8'h00;
      t_q     <= 8'h00;
      out_q   <= 8'h00;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      t_q     <= t_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign byte_out  = out_q;
endmodule

// File: tb/tb_inv_sbox_iter.sv
// tb_inv_sbox_iter: directed and swept checks of inv_sbox_iter against a forward S-box model
module tb_inv_sbox_iter;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       in_ready, out_valid, busy;
  logic [7:0] byte_out;
  int         n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] sbox_t [256];
  logic [7:0] isb [256];

  inv_sbox_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .byte_in(byte_in),
    .out_valid(out_valid), .out_ready(out_ready), .byte_out(byte_out), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // carry-less product then reduction by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic xact(input logic [7:0] b, output logic [7:0] r, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    byte_in  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = byte_out;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] r, inv;
    int         lat, idx, res, guard;
    logic [7:0] vin [4]  = '{8'h63, 8'h7c, 8'h00, 8'h16};
    logic [7:0] vexp [4] = '{8'h00, 8'h01, 8'h52, 8'hff};
    int         acc [4];
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gf_mul(8'(x), 8'(j)) == 8'h01) inv = 8'(j);
      sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sbox_t[x]] = 8'(x);

    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_byte_out", 32'(byte_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // zero-inverse path, with CALC-state flags sampled along the way
    in_valid = 1'b1;
    byte_in  = 8'h63;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("calc_busy", 32'(busy), 1);
    check("calc_in_ready", 32'(in_ready), 0);
    check("calc_out_valid", 32'(out_valid), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("z_lat", 32'(lat), 7);
    check("z_val", 32'(byte_out), 8'h00);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("z_drop", 32'(out_valid), 0);

    for (int k = 1; k < 4; k++) begin
      xact(vin[k], r, lat);
      check($sformatf("dir_%0h", vin[k]), 32'(r), 32'(vexp[k]));
      check($sformatf("dir_lat_%0h", vin[k]), 32'(lat), 7);
    end
    xact(8'hed, r, lat);
    check("dir_ed", 32'(r), 8'h53);
    check("hold_idle", 32'(byte_out), 8'h53);

    for (int x = 0; x < 256; x++) begin
      xact(8'(x), r, lat);
      check($sformatf("sweep_%0h", x), 32'(r), 32'(isb[x]));
      check($sformatf("sweep_lat_%0h", x), 32'(lat), 7);
    end

    // stall in DONE while new requests are offered
    @(negedge clk);
    in_valid = 1'b1;
    byte_in  = 8'h7c;
    @(posedge clk);
    @(negedge clk);
    byte_in = 8'h00;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("stall_lat", 32'(lat), 7);
    for (int k = 0; k < 5; k++) begin
      byte_in = ~byte_in;
      @(negedge clk);
      check("stall_byte_out", 32'(byte_out), 8'h01);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release_ov", 32'(out_valid), 0);
    check("stall_release_ir", 32'(in_ready), 1);
    @(negedge clk);
    check("stall_single", 32'(busy), 0);

    // asynchronous reset during CALC
    in_valid = 1'b1;
    byte_in  = 8'h16;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_byte_out", 32'(byte_out), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    #1 rst = 1'b0;
    xact(8'hed, r, lat);
    check("post_rst_val", 32'(r), 8'h53);
    check("post_rst_lat", 32'(lat), 7);

    // back-to-back with in_valid held high
    idx = 0;
    res = 0;
    guard = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (res < 4 && guard < 80) begin
      if (out_valid) begin
        check($sformatf("b2b_res_%0d", res), 32'(byte_out), 32'(vexp[res]));
        res++;
      end
      if (in_ready) begin
        if (idx < 4) begin
          in_valid = 1'b1;
          byte_in  = vin[idx];
          acc[idx] = cyc;
          idx++;
        end else in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", 32'(res), 4);
    for (int k = 1; k < 4; k++) check($sformatf("b2b_gap_%0d", k), 32'(acc[k] - acc[k-1]), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
